// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared state encoding, requester indices and sizing helper for the RAM write controller
package ram_ctrl_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_ARB   = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // A single-word RAM still needs a one-bit address port.
  function automatic int depth_log(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with one-hot grant, pointer kept by the caller
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // ptr names the requester that wins when both are valid.
  always_comb begin
    grant     = 2'b00;
    grant_idx = REQ0;
    if (rst_n && enable) begin
      if (valid[0] && (!valid[1] || (ptr == REQ0))) begin
        grant     = 2'b01;
        grant_idx = REQ0;
      end else if (valid[1]) begin
        grant     = 2'b10;
        grant_idx = REQ1;
      end
    end
  end

endmodule

// File: rtl/ram_dp_wr_arbiter.sv
// rtl/ram_dp_wr_arbiter.sv - clears the RAM, then shares its write port between two requesters
module ram_dp_wr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 16,
  parameter logic [WIDTH-1:0] CLR_VAL   = {WIDTH{1'b0}},
  parameter int               DEPTH_LOG = depth_log(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_start,
  output logic                 busy,
  input  logic                 req0_valid,
  input  logic [DEPTH_LOG-1:0] req0_addr,
  input  logic [WIDTH-1:0]     req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DEPTH_LOG-1:0] req1_addr,
  input  logic [WIDTH-1:0]     req1_data,
  output logic                 req1_ready,
  output logic                 ram_we,
  output logic [DEPTH_LOG-1:0] ram_addr_wr,
  output logic [WIDTH-1:0]     ram_data_wr,
  output logic                 last_grant
);

  localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);

  logic [0:0]           state;
  logic [DEPTH_LOG-1:0] clr_cnt;
  logic                 ptr;
  logic                 arb_en;
  logic [1:0]           grant;
  logic                 grant_idx;

  assign busy   = (state == ST_CLEAR);
  // A clear request suppresses any grant in the same cycle.
  assign arb_en = (state == ST_ARB) && !clr_start;

  rr_arb2 u_arb (
    .rst_n     (rst_n),
    .enable    (arb_en),
    .valid     ({req1_valid, req0_valid}),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_CLEAR;
      clr_cnt     <= '0;
      ptr         <= REQ0;
      last_grant  <= REQ0;
      ram_we      <= 1'b0;
      ram_addr_wr <= '0;
      ram_data_wr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          ram_we      <= 1'b1;
          ram_addr_wr <= clr_cnt;
          ram_data_wr <= CLR_VAL;
          if (clr_cnt == LAST_ADDR) begin
            state <= ST_ARB;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          ram_we <= |grant;
          if (clr_start) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end else if (|grant) begin
            // addr/data are sampled only here, at the handshake edge.
            ram_addr_wr <= (grant_idx == REQ1) ? req1_addr : req0_addr;
            ram_data_wr <= (grant_idx == REQ1) ? req1_data : req0_data;
            ptr         <= ~grant_idx;
            last_grant  <= grant_idx;
          end
        end
      endcase
    end
  end

endmodule
